// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Select sequencer and sampler for a shared 4:1 mux. Steps the mux select
//   through inputs 0..3, holding each for DIV clocks, samples the mux output
//   in the last cycle of each slot and presents the four samples as one
//   parallel word with a one-cycle valid strobe.
//
// Parameters
//   DIV    clock cycles per select slot (1..255)
//
// Ports
//   clk    in   system clock, rising edge
//   clr    in   asynchronous active-high reset
//   start  in   request one scan of all four mux inputs
//   y_in   in   mux output (depends combinationally on s)
//   s      out  [1:0] registered mux select
//   q      out  [3:0] captured word, q[i] = y_in seen while s == i
//   valid  out  one-cycle strobe, q updated on this edge
//   busy   out  scan in progress
//
// Build option
//   MUX_SCAN_CONT_EN  when defined, the block scans continuously from the
//                     first edge after reset release and ignores start.
module mux_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       y_in,
  output logic [1:0] s,
  output logic [3:0] q,
  output logic       valid,
  output logic       busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      s_nxt;
  logic [2:0]      sh, sh_nxt;
  logic [3:0]      q_nxt;
  logic            valid_nxt;
  logic            go;
  logic            wrap;

`ifdef MUX_SCAN_CONT_EN
  // start has no effect in continuous mode; the scan restarts on its own.
  assign go   = start | 1'b1;
  assign wrap = 1'b1;
`else
  assign go   = start;
  assign wrap = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      s     <= 2'd0;
      cnt   <= '0;
      sh    <= 3'd0;
      q     <= 4'd0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
      q     <= q_nxt;
      valid <= valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    q_nxt     = q;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        s_nxt = 2'd0;
        if (go) begin
          state_nxt = SCAN;
          cnt_nxt   = CNT_LOAD;
        end
      end
      SCAN: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (s != 2'd3) begin
          // Last cycle of slot s: the mux has settled, take the sample.
          sh_nxt[s] = y_in;
          s_nxt     = s + 2'd1;
          cnt_nxt   = CNT_LOAD;
        end else begin
          q_nxt     = {y_in, sh};
          valid_nxt = 1'b1;
          s_nxt     = 2'd0;
          if (wrap) begin
            cnt_nxt = CNT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state == SCAN);
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       st   [3];
  logic [3:0] a    [3];
  logic       y    [3];
  logic [1:0] s_o  [3];
  logic [3:0] q_o  [3];
  logic       v_o  [3];
  logic       b_o  [3];
  int         divs [3] = '{4, 1, 2};

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Mux sources: a[i] are the four single-bit inputs seen through the mux.
  for (genvar g = 0; g < 3; g++) begin : g_mux
    assign y[g] = a[g][s_o[g]];
  end

  mux_scan_ctrl #(.DIV(4)) u0 (.clk(clk), .clr(clr), .start(st[0]), .y_in(y[0]),
                               .s(s_o[0]), .q(q_o[0]), .valid(v_o[0]), .busy(b_o[0]));
  mux_scan_ctrl #(.DIV(1)) u1 (.clk(clk), .clr(clr), .start(st[1]), .y_in(y[1]),
                               .s(s_o[1]), .q(q_o[1]), .valid(v_o[1]), .busy(b_o[1]));
  mux_scan_ctrl #(.DIV(2)) u2 (.clk(clk), .clr(clr), .start(st[2]), .y_in(y[2]),
                               .s(s_o[2]), .q(q_o[2]), .valid(v_o[2]), .busy(b_o[2]));

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[u%0d] got %0h want %0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Reference model: tracks edges elapsed since the scan began; the slot
  // number is that count divided by DIV, and a sample is taken whenever the
  // count reaches a whole multiple of DIV.
  bit         m_act  [3];
  int         m_n    [3];
  logic [1:0] m_s    [3];
  logic [3:0] m_bits [3];
  logic [3:0] m_q    [3];
  bit         m_v    [3];

  always @(posedge clk or posedge clr) begin
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_act[i] = 0; m_n[i] = 0; m_s[i] = 2'd0;
        m_bits[i] = 4'd0; m_q[i] = 4'd0; m_v[i] = 0;
      end else begin
        m_v[i] = 0;
        if (!m_act[i]) begin
          if (st[i] || CONT) begin
            m_act[i] = 1;
            m_n[i]   = 0;
          end
          m_s[i] = 2'd0;
        end else begin
          m_n[i]++;
          if (m_n[i] % divs[i] == 0) begin
            int k;
            k = m_n[i] / divs[i] - 1;
            m_bits[i][k] = a[i][m_s[i]];
            if (k == 3) begin
              m_q[i]   = m_bits[i];
              m_v[i]   = 1;
              m_n[i]   = 0;
              m_act[i] = CONT;
            end
          end
          m_s[i] = m_act[i] ? 2'(m_n[i] / divs[i]) : 2'd0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("s",     i, 32'(s_o[i]), 32'(m_s[i]));
      chk("q",     i, 32'(q_o[i]), 32'(m_q[i]));
      chk("valid", i, 32'(v_o[i]), 32'(m_v[i]));
      chk("busy",  i, 32'(b_o[i]), 32'(m_act[i]));
    end
  end

  task automatic pulse(input int i);
    @(negedge clk); st[i] = 1'b1;
    @(negedge clk); st[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int lim, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!v_o[i] && c < lim);
    if (!v_o[i]) chk("valid_timeout", i, 32'(v_o[i]), 32'd1);
  endtask

  initial begin
    int c, nv;
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; a[i] = 4'd0; end
    repeat (2) @(negedge clk);
    chk("rst_s", 0, 32'(s_o[0]), 32'd0);
    chk("rst_q", 0, 32'(q_o[0]), 32'd0);
    chk("rst_valid", 0, 32'(v_o[0]), 32'd0);
    chk("rst_busy", 0, 32'(b_o[0]), 32'd0);

`ifndef MUX_SCAN_CONT_EN
    a[2] = 4'b1001;
    clr = 1'b0;

    // DIV=4 basic scan
    a[0] = 4'b1010;
    pulse(0);
    chk("busy_after_start", 0, 32'(b_o[0]), 32'd1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 3) chk("s_slot0_last", 0, 32'(s_o[0]), 32'd0);
      if (c == 4) chk("s_slot1_first", 0, 32'(s_o[0]), 32'd1);
    end while (!v_o[0] && c < 40);
    chk("latency_div4", 0, 32'(c), 32'd16);
    chk("q_1010", 0, 32'(q_o[0]), 32'b1010);
    chk("busy_at_valid", 0, 32'(b_o[0]), 32'd0);
    @(negedge clk);
    chk("valid_one_cycle", 0, 32'(v_o[0]), 32'd0);

    // DIV=1 scan, then start held high
    a[1] = 4'b0110;
    pulse(1);
    wait_valid(1, 20, c);
    chk("latency_div1", 1, 32'(c), 32'd4);
    chk("q_0110", 1, 32'(q_o[1]), 32'b0110);
    @(negedge clk); st[1] = 1'b1;
    wait_valid(1, 20, c);
    wait_valid(1, 20, c);
    chk("period_held_1", 1, 32'(c), 32'd5);
    wait_valid(1, 20, c);
    chk("period_held_2", 1, 32'(c), 32'd5);
    st[1] = 1'b0;
    repeat (8) @(negedge clk);

    // DIV=2 single scan
    pulse(2);
    wait_valid(2, 30, c);
    chk("latency_div2", 2, 32'(c), 32'd8);
    chk("q_1001", 2, 32'(q_o[2]), 32'b1001);

    // start during a scan is ignored
    a[0] = 4'b1111;
    pulse(0);
    repeat (8) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    wait_valid(0, 40, c);
    chk("latency_ignored_start", 0, 32'(c), 32'd7);
    chk("q_1111", 0, 32'(q_o[0]), 32'b1111);
    nv = 0;
    repeat (20) begin @(negedge clk); if (v_o[0]) nv++; end
    chk("no_extra_valid", 0, 32'(nv), 32'd0);

    // clr during slot 1 aborts the scan
    pulse(0);
    repeat (5) @(negedge clk);
    chk("s_before_abort", 0, 32'(s_o[0]), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("abort_s", 0, 32'(s_o[0]), 32'd0);
    chk("abort_q", 0, 32'(q_o[0]), 32'd0);
    chk("abort_valid", 0, 32'(v_o[0]), 32'd0);
    chk("abort_busy", 0, 32'(b_o[0]), 32'd0);
    #1 clr = 1'b0;
    nv = 0;
    repeat (30) begin @(negedge clk); if (v_o[0]) nv++; end
    chk("no_valid_after_abort", 0, 32'(nv), 32'd0);
    chk("q_zero_after_abort", 0, 32'(q_o[0]), 32'd0);

    // glitch in slot 0 ignored: bit 0 drops back before the last cycle
    a[0] = 4'b1001;
    pulse(0);
    repeat (3) @(negedge clk);
    a[0] = 4'b1000;
    wait_valid(0, 40, c);
    chk("latency_glitch", 0, 32'(c), 32'd13);
    chk("q_last_cycle_sample", 0, 32'(q_o[0]), 32'b1000);
    repeat (4) @(negedge clk);
`else
    // continuous mode, DIV=2 instance
    a[2] = 4'b1001;
    clr = 1'b0;
    wait_valid(2, 30, c);
    chk("cont_first_q", 2, 32'(q_o[2]), 32'b1001);
    wait_valid(2, 30, c);
    chk("cont_period_1", 2, 32'(c), 32'd8);
    chk("cont_q_1001", 2, 32'(q_o[2]), 32'b1001);
    chk("cont_busy", 2, 32'(b_o[2]), 32'd1);
    repeat (4) @(negedge clk);
    a[2] = 4'b0011;
    pulse(2);
    wait_valid(2, 30, c);
    chk("cont_mixed_q", 2, 32'(q_o[2]), 32'b0001);
    wait_valid(2, 30, c);
    chk("cont_period_2", 2, 32'(c), 32'd8);
    chk("cont_q_0011", 2, 32'(q_o[2]), 32'b0011);
    chk("cont_busy_2", 2, 32'(b_o[2]), 32'd1);
    repeat (4) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
